// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
// MAX_HOLD must stay within MAX_HOLD_MIN..MAX_HOLD_MAX so hold_cnt fits in SEL_W bits.
package mux16_rr_arbiter_pkg;

  localparam int unsigned NREQ         = 16;
  localparam int unsigned SEL_W        = 4;
  localparam int unsigned MAX_HOLD_MIN = 1;
  localparam int unsigned MAX_HOLD_MAX = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux16_rr_arbiter_mux16to1.sv
// 16-to-1 single-bit mux built as two levels of 4-to-1 stages.
module mux16to1
  import mux16_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  data_in,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  logic [3:0] stage;

  function automatic logic mux4(input logic [3:0] d, input logic [1:0] s);
    return d[s];
  endfunction

  always_comb begin
    stage = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      stage[i] = mux4(data_in[4*i +: 4], sel[1:0]);
    end
    y = mux4(stage, sel[3:2]);
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter owning the shared 16-to-1 select path; bounded-burst grants
// with zero-bubble handover and the granted requester's data bit routed out.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  data_in,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             data_out
);

  localparam logic [SEL_W-1:0] HOLD_LAST = SEL_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] hold_cnt, hold_n;
  logic [SEL_W-1:0] sel_n;
  logic [NREQ-1:0]  gnt_n;
  logic             busy_n;
  logic             others;
  logic [SEL_W-1:0] nxt;
  logic [SEL_W-1:0] winner;
  logic             mux_y;

  // First set bit scanning upward from start, wrapping 15 -> 0.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = start + SEL_W'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    sel_n   = sel;
    gnt_n   = gnt;
    busy_n  = busy;
    winner  = '0;
    others  = |(req & ~gnt);
    nxt     = sel + 1'b1;

    case (state)
      IDLE: begin
        if (|req) begin
          winner        = rr_pick(req, ptr);
          state_n       = GRANT;
          sel_n         = winner;
          gnt_n         = '0;
          gnt_n[winner] = 1'b1;
          busy_n        = 1'b1;
          hold_n        = '0;
        end
      end
      GRANT: begin
        // Drop and forced rotation share one path: both advance ptr past sel.
        if (!req[sel] || (others && hold_cnt == HOLD_LAST)) begin
          ptr_n  = nxt;
          hold_n = '0;
          if (others) begin
            winner        = rr_pick(req & ~gnt, nxt);
            sel_n         = winner;
            gnt_n         = '0;
            gnt_n[winner] = 1'b1;
          end else begin
            state_n = IDLE;
            sel_n   = '0;
            gnt_n   = '0;
            busy_n  = 1'b0;
          end
        end else if (hold_cnt != HOLD_LAST) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      sel      <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
    end
  end

  mux16to1 u_mux (
    .data_in (data_in),
    .sel     (sel),
    .y       (mux_y)
  );

  assign data_out = mux_y & busy;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: fixed vector table, full-contention sequence and
// random traffic checked against a grant-tracking reference model.
module tb_mux16_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic [15:0] data_in;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        busy;
  logic        data_out;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant (-1 = nobody), priority start, cycles held.
  int m_g;
  int m_ptr;
  int m_held;

  mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] din;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;
    logic        dout;
  } vec_t;

  vec_t tbl[21];

  function automatic int first_from(input logic [15:0] r, input int p);
    for (int i = 0; i < 16; i++) begin
      if (r[(p + i) % 16]) return (p + i) % 16;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic rst, input logic [15:0] r);
    logic [15:0] oth;
    if (rst) begin
      m_g = -1; m_ptr = 0; m_held = 0;
    end else if (m_g < 0) begin
      if (r != 16'h0) begin
        m_g = first_from(r, m_ptr);
        m_held = 1;
      end
    end else begin
      oth = r;
      oth[m_g] = 1'b0;
      if (!r[m_g] || (oth != 16'h0 && m_held >= MAX_HOLD)) begin
        m_ptr = (m_g + 1) % 16;
        if (oth != 16'h0) begin
          m_g = first_from(oth, m_ptr);
          m_held = 1;
        end else begin
          m_g = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic        r;
    logic [15:0] q;
    r = reset;
    q = req;
    @(posedge clk);
    model_edge(r, q);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [15:0] eg;
    logic [3:0]  es;
    logic        eb;
    logic        ed;
    eg = 16'h0; es = 4'd0; eb = 1'b0; ed = 1'b0;
    if (m_g >= 0) begin
      eg[m_g] = 1'b1;
      es = 4'(m_g);
      eb = 1'b1;
      ed = data_in[m_g];
    end
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_sel"}, 32'(sel), 32'(es));
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
    chk({tag, "_dout"}, 32'(data_out), 32'(ed));
  endtask

  initial begin
    reset = 1'b1; req = '0; data_in = '0;
    m_g = -1; m_ptr = 0; m_held = 0;

    tbl[0]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0020, 16'h0020, 16'h0020, 4'd5,  1'b1, 1'b1};
    tbl[3]  = '{1'b0, 16'h0020, 16'h0000, 16'h0020, 4'd5,  1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0020, 16'hFFFF, 16'h0020, 4'd5,  1'b1, 1'b1};
    tbl[5]  = '{1'b0, 16'h0020, 16'h0000, 16'h0020, 4'd5,  1'b1, 1'b0};
    tbl[6]  = '{1'b0, 16'h0020, 16'h0020, 16'h0020, 4'd5,  1'b1, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0020, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h0008, 16'h0008, 16'h0008, 4'd3,  1'b1, 1'b1};
    tbl[10] = '{1'b0, 16'h0208, 16'h0000, 16'h0008, 4'd3,  1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'h0204, 16'h0200, 16'h0200, 4'd9,  1'b1, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[13] = '{1'b0, 16'h4000, 16'h4000, 16'h4000, 4'd14, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 16'h8004, 16'h0000, 16'h8000, 4'd15, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 16'h0004, 16'hFFFF, 16'h0004, 4'd2,  1'b1, 1'b1};
    tbl[16] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[17] = '{1'b0, 16'h0800, 16'h0800, 16'h0800, 4'd11, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 16'h0800, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};
    tbl[19] = '{1'b0, 16'h8001, 16'h0001, 16'h0001, 4'd0,  1'b1, 1'b1};
    tbl[20] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0};

    for (int i = 0; i < 21; i++) begin
      reset = tbl[i].rst; req = tbl[i].req; data_in = tbl[i].din;
      step();
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
    end

    // Full contention: order 0..15,0 with exactly MAX_HOLD cycles each, no gaps.
    reset = 1'b1; req = 16'h0000;
    step();
    reset = 1'b0; req = 16'hFFFF;
    for (int k = 0; k < 17 * MAX_HOLD; k++) begin
      data_in = 16'($urandom);
      step();
      chk($sformatf("cont%0d_sel", k), 32'(sel), 32'((k / MAX_HOLD) % 16));
      chk($sformatf("cont%0d_busy", k), 32'(busy), 32'd1);
      chk($sformatf("cont%0d_gnt", k), 32'(gnt), 32'(16'h1 << ((k / MAX_HOLD) % 16)));
      chk($sformatf("cont%0d_dout", k), 32'(data_out), 32'(data_in[(k / MAX_HOLD) % 16]));
    end

    // Random traffic: requests persist with occasional bit flips so bursts and
    // rotations both occur; sparse resets.
    reset = 1'b1; req = '0;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0:       req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        1:       req = 16'h0;
        2, 3:    req = req ^ (16'h1 << $urandom_range(0, 15));
        default: req = req;
      endcase
      data_in = 16'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      step();
      check_model("rand");
      chk("rand_onehot", 32'(gnt), busy ? 32'(16'h1 << sel) : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
